// File: rtl/change_dispenser.sv
// change_dispenser
//   Returns change owed after a vending sale or cancel. Coins are chosen greedily,
//   largest first, from the coins actually in the tubes. Each coin is ejected as a
//   one-cycle solenoid pulse. There is always at least one idle cycle between pulses.
//   Any amount that cannot be paid out is reported as a shortfall.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   req, change_amt[8:0]     start request and amount in cents (sampled in IDLE)
//   refill                   reload all tubes to their INIT counts (IDLE only)
//   busy                     high whenever not IDLE
//   coin_q/coin_d/coin_n     one-cycle eject pulses (quarter/dime/nickel)
//   done                     one-cycle transaction-complete pulse
//   shortfall[8:0]           cents not returned, held until the next accepted req
//   quart/dim/nick           coins of each type ejected in the current/last transaction
//   q_left/d_left/n_left     current tube inventory
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for req; refill honoured here
// SEL   | pick the largest affordable, available coin, or finish
// EJECT | solenoid pulse cycle; forces a gap before the next pick
// DONE  | done pulse; counts and shortfall now final
module change_dispenser #(
    parameter int TUBE_W = 5,
    parameter int Q_INIT = 20,
    parameter int D_INIT = 20,
    parameter int N_INIT = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [8:0]        change_amt,
    input  logic              refill,
    output logic              busy,
    output logic              coin_q,
    output logic              coin_d,
    output logic              coin_n,
    output logic              done,
    output logic [8:0]        shortfall,
    output logic [TUBE_W-1:0] quart,
    output logic [TUBE_W-1:0] dim,
    output logic [TUBE_W-1:0] nick,
    output logic [TUBE_W-1:0] q_left,
    output logic [TUBE_W-1:0] d_left,
    output logic [TUBE_W-1:0] n_left
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SEL   = 2'd1;
    localparam logic [1:0] EJECT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [TUBE_W-1:0] Q_FULL = TUBE_W'(Q_INIT);
    localparam logic [TUBE_W-1:0] D_FULL = TUBE_W'(D_INIT);
    localparam logic [TUBE_W-1:0] N_FULL = TUBE_W'(N_INIT);
    localparam logic [TUBE_W-1:0] ONE    = TUBE_W'(1);

    logic [1:0] state;
    logic [8:0] rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rem       <= 9'd0;
            busy      <= 1'b0;
            coin_q    <= 1'b0;
            coin_d    <= 1'b0;
            coin_n    <= 1'b0;
            done      <= 1'b0;
            shortfall <= 9'd0;
            quart     <= '0;
            dim       <= '0;
            nick      <= '0;
            q_left    <= Q_FULL;
            d_left    <= D_FULL;
            n_left    <= N_FULL;
        end else begin
            // Pulses last one cycle unless a branch below re-asserts them.
            coin_q <= 1'b0;
            coin_d <= 1'b0;
            coin_n <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    // Refill lands on the same edge as an accepted req, so the
                    // first SEL already sees the full tubes.
                    if (refill) begin
                        q_left <= Q_FULL;
                        d_left <= D_FULL;
                        n_left <= N_FULL;
                    end
                    if (req) begin
                        rem       <= change_amt;
                        quart     <= '0;
                        dim       <= '0;
                        nick      <= '0;
                        shortfall <= 9'd0;
                        busy      <= 1'b1;
                        state     <= SEL;
                    end
                end
                SEL: begin
                    // Each coin is taken only while rem covers its value, so rem
                    // never wraps and an empty tube is never decremented.
                    if (rem >= 9'd25 && q_left != '0) begin
                        coin_q <= 1'b1;
                        rem    <= rem - 9'd25;
                        quart  <= quart + ONE;
                        q_left <= q_left - ONE;
                        state  <= EJECT;
                    end else if (rem >= 9'd10 && d_left != '0) begin
                        coin_d <= 1'b1;
                        rem    <= rem - 9'd10;
                        dim    <= dim + ONE;
                        d_left <= d_left - ONE;
                        state  <= EJECT;
                    end else if (rem >= 9'd5 && n_left != '0) begin
                        coin_n <= 1'b1;
                        rem    <= rem - 9'd5;
                        nick   <= nick + ONE;
                        n_left <= n_left - ONE;
                        state  <= EJECT;
                    end else begin
                        done      <= 1'b1;
                        shortfall <= rem;
                        state     <= DONE;
                    end
                end
                EJECT: begin
                    state <= SEL;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Drives three dispensers from the same stimulus. They differ only in tube
// contents: the default, Q_INIT=1, and N_INIT=0. A greedy reference model
// builds the expected per-cycle trace {busy,coin_q,coin_d,coin_n,done} for each
// instance, and the final counts/tubes at done. The monitor pops and compares
// that trace once per cycle.
module tb_change_dispenser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       refill = 1'b0;
    logic [8:0] change_amt = 9'd0;

    logic       busy_w[3], coin_q_w[3], coin_d_w[3], coin_n_w[3], done_w[3];
    logic [8:0] sf_w[3];
    logic [4:0] quart_w[3], dim_w[3], nick_w[3], ql_w[3], dl_w[3], nl_w[3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        change_dispenser #(
            .TUBE_W(5),
            .Q_INIT(g == 1 ? 1 : 20),
            .D_INIT(20),
            .N_INIT(g == 2 ? 0 : 20)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req       (req),
            .change_amt(change_amt),
            .refill    (refill),
            .busy      (busy_w[g]),
            .coin_q    (coin_q_w[g]),
            .coin_d    (coin_d_w[g]),
            .coin_n    (coin_n_w[g]),
            .done      (done_w[g]),
            .shortfall (sf_w[g]),
            .quart     (quart_w[g]),
            .dim       (dim_w[g]),
            .nick      (nick_w[g]),
            .q_left    (ql_w[g]),
            .d_left    (dl_w[g]),
            .n_left    (nl_w[g])
        );
    end

    typedef struct {
        logic [4:0] sig;
        bit         chk;
        int         sf, cq, cd, cn, lq, ld, ln;
    } exp_t;

    exp_t exp_q[3][$];
    exp_t mon_e;
    int   mq[3], md[3], mn[3];
    int   n_chk = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    function automatic int qinit(input int i);
        return (i == 1) ? 1 : 20;
    endfunction

    function automatic int ninit(input int i);
        return (i == 2) ? 0 : 20;
    endfunction

    function automatic exp_t mk(input logic [4:0] s);
        exp_t e;
        e.sig = s; e.chk = 1'b0;
        e.sf = 0; e.cq = 0; e.cd = 0; e.cn = 0;
        e.lq = 0; e.ld = 0; e.ln = 0;
        return e;
    endfunction

    task automatic chk_val(input string tag, input int got, input int expv);
        n_chk++;
        if (got != expv) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, expv, $time);
        end
    endtask

    task automatic model_reload();
        for (int i = 0; i < 3; i++) begin
            mq[i] = qinit(i);
            md[i] = 20;
            mn[i] = ninit(i);
        end
    endtask

    function automatic bit any_inv();
        bit r = 1'b0;
        for (int i = 0; i < 3; i++)
            if (mq[i] + md[i] + mn[i] > 0) r = 1'b1;
        return r;
    endfunction

    function automatic bit pending();
        return (exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) > 0;
    endfunction

    // Expected trace: the request cycle (idle), SEL, then EJECT/SEL pairs, then DONE.
    task automatic push_txn(input int amt);
        exp_t e;
        int rem, cq, cd, cn;
        for (int i = 0; i < 3; i++) begin
            rem = amt; cq = 0; cd = 0; cn = 0;
            exp_q[i].push_back(mk(5'b00000));
            exp_q[i].push_back(mk(5'b10000));
            for (int s = 0; s < 70; s++) begin
                if (rem >= 25 && mq[i] > 0) begin
                    rem -= 25; mq[i]--; cq++;
                    exp_q[i].push_back(mk(5'b11000));
                    exp_q[i].push_back(mk(5'b10000));
                end else if (rem >= 10 && md[i] > 0) begin
                    rem -= 10; md[i]--; cd++;
                    exp_q[i].push_back(mk(5'b10100));
                    exp_q[i].push_back(mk(5'b10000));
                end else if (rem >= 5 && mn[i] > 0) begin
                    rem -= 5; mn[i]--; cn++;
                    exp_q[i].push_back(mk(5'b10010));
                    exp_q[i].push_back(mk(5'b10000));
                end else begin
                    e = mk(5'b10001);
                    e.chk = 1'b1; e.sf = rem;
                    e.cq = cq; e.cd = cd; e.cn = cn;
                    e.lq = mq[i]; e.ld = md[i]; e.ln = mn[i];
                    exp_q[i].push_back(e);
                    break;
                end
            end
        end
    endtask

    // Expected state right after a reset: idle, counts clear, tubes full.
    task automatic push_reset_state();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e = mk(5'b00000);
            e.chk = 1'b1;
            e.lq = qinit(i); e.ld = 20; e.ln = ninit(i);
            exp_q[i].push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                if (exp_q[i].size() > 0) mon_e = exp_q[i].pop_front();
                else mon_e = mk(5'b00000);
                chk_val($sformatf("u%0d.sig", i),
                        int'({busy_w[i], coin_q_w[i], coin_d_w[i], coin_n_w[i], done_w[i]}),
                        int'(mon_e.sig));
                if (mon_e.chk) begin
                    chk_val($sformatf("u%0d.shortfall", i), int'(sf_w[i]), mon_e.sf);
                    chk_val($sformatf("u%0d.quart", i), int'(quart_w[i]), mon_e.cq);
                    chk_val($sformatf("u%0d.dim", i), int'(dim_w[i]), mon_e.cd);
                    chk_val($sformatf("u%0d.nick", i), int'(nick_w[i]), mon_e.cn);
                    chk_val($sformatf("u%0d.q_left", i), int'(ql_w[i]), mon_e.lq);
                    chk_val($sformatf("u%0d.d_left", i), int'(dl_w[i]), mon_e.ld);
                    chk_val($sformatf("u%0d.n_left", i), int'(nl_w[i]), mon_e.ln);
                end
            end
        end
    end

    // Called at posedge+1: the request is sampled on the next edge.
    task automatic start(input int amt, input bit rf);
        if (rf) model_reload();
        req = 1'b1; change_amt = 9'(amt); refill = rf;
        push_txn(amt);
        @(posedge clk); #1;
        req = 1'b0; change_amt = 9'd0; refill = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (pending() && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk_val("wait_idle_in_budget", int'(n < 300), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reload();
        push_reset_state();
        mon_en = 1'b1;
        @(posedge clk); #1;

        // 65: Q Q D N, done at k+10.
        start(65, 1'b0);
        wait_idle();
        chk_val("c65.quart", int'(quart_w[0]), 2);
        chk_val("c65.dim", int'(dim_w[0]), 1);
        chk_val("c65.nick", int'(nick_w[0]), 1);
        chk_val("c65.q_left", int'(ql_w[0]), 18);
        chk_val("c65.d_left", int'(dl_w[0]), 19);
        chk_val("c65.n_left", int'(nl_w[0]), 19);

        // 37 leaves 2 cents; 0 finishes at k+2 with nothing ejected.
        start(37, 1'b0);
        wait_idle();
        chk_val("c37.shortfall", int'(sf_w[0]), 2);
        start(0, 1'b0);
        wait_idle();

        // req and refill while busy must not disturb the transaction.
        start(65, 1'b0);
        @(posedge clk); #1;
        req = 1'b1; change_amt = 9'd200; refill = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req = 1'b0; change_amt = 9'd0; refill = 1'b0;
        wait_idle();

        // Reset in the cycle after the second pulse: idle next edge, tubes full.
        start(65, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++)
            while (exp_q[i].size() > 1) void'(exp_q[i].pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) exp_q[i].delete();
        model_reload();
        push_reset_state();
        @(posedge clk); #1;
        repeat (4) begin
            @(posedge clk); #1;
        end

        // Q_INIT=1: 50 -> Q D D N, then 25 -> D D N. N_INIT=0: 30 -> Q, 5 short.
        start(50, 1'b0);
        wait_idle();
        chk_val("q1.c50.q_left", int'(ql_w[1]), 0);
        chk_val("q1.c50.dim", int'(dim_w[1]), 2);
        start(25, 1'b0);
        wait_idle();
        chk_val("q1.c25.dim", int'(dim_w[1]), 2);
        chk_val("q1.c25.nick", int'(nick_w[1]), 1);
        start(30, 1'b0);
        wait_idle();
        chk_val("n0.c30.quart", int'(quart_w[2]), 1);
        chk_val("n0.c30.shortfall", int'(sf_w[2]), 5);

        // Drain, then refill together with req(40).
        for (int it = 0; it < 4 && any_inv(); it++) begin
            start(511, 1'b0);
            wait_idle();
        end
        chk_val("drained", int'(ql_w[0]) + int'(dl_w[0]) + int'(nl_w[0]), 0);
        start(40, 1'b1);
        wait_idle();
        chk_val("refill40.q_left", int'(ql_w[0]), 19);
        chk_val("refill40.d_left", int'(dl_w[0]), 19);
        chk_val("refill40.n_left", int'(nl_w[0]), 19);
        chk_val("refill40.shortfall", int'(sf_w[0]), 0);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
